pipeline_stall_controller: RTL

- Central hazard/stall sequencer for the 5-stage MIPS32 pipeline; drives the if/id/ex/mem stall lines consumed by the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use and branch-operand hazards, tracks the multi-cycle mul/div unit with a busy counter, and runs the data-memory wait-state handshake FSM with a timeout.
- Stall semantics: stage N stall holds that stage's register. id_stall without ex_stall injects a bubble into EX.

---
 rtl/pipeline_stall_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall sequencer for the 5-stage MIPS32 pipeline: load-use and
// branch-operand hazards, mul/div busy tracking and the data-memory
// wait-state handshake with timeout.
module pipeline_stall_controller #(
  parameter int unsigned MULDIV_LATENCY = 32,
  parameter int unsigned DMEM_TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_branch,
  input  logic [4:0]           ex_dst,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic                 ex_muldiv_start,
  input  logic                 ex_muldiv_use,
  input  logic [4:0]           mem_dst,
  input  logic                 mem_mem_read,
  input  logic                 mem_mem_write,
  input  logic                 dmem_ready,
  output logic                 if_stall,
  output logic                 id_stall,
  output logic                 ex_stall,
  output logic                 mem_stall,
  output logic                 dmem_req,
  output logic                 muldiv_busy,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] stall_cycle_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned TO_W  = 8;
  localparam int unsigned MD_W  = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;

  localparam logic [MD_W-1:0]  MD_LOAD  = MD_W'(MULDIV_LATENCY - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(DMEM_TIMEOUT);
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dmem_state_e;

  dmem_state_e          state_q, state_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [MD_W-1:0]      md_cnt_q;
  logic                 bus_error_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  logic access;
  logic dmem_wait;
  logic timeout_hit;
  logic md_start_ok;
  logic ex_wr_nz, mem_ld_nz;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, branch_haz;

  // Source/destination match terms; $0 never produces a hazard
  assign ex_wr_nz   = ex_reg_write & (ex_dst != REG_ZERO);
  assign mem_ld_nz  = mem_mem_read & (mem_dst != REG_ZERO);
  assign rs_ex      = id_uses_rs & (id_rs == ex_dst);
  assign rt_ex      = id_uses_rt & (id_rt == ex_dst);
  assign rs_mem     = id_uses_rs & (id_rs == mem_dst);
  assign rt_mem     = id_uses_rt & (id_rt == mem_dst);
  assign load_use   = ex_mem_read & ex_wr_nz & (rs_ex | rt_ex);
  assign branch_haz = id_branch & ((ex_wr_nz & (rs_ex | rt_ex)) |
                                   (mem_ld_nz & (rs_mem | rt_mem)));

  assign access = mem_mem_read | mem_mem_write;

  // Data-memory handshake: next state, request strobe and wait indication
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    dmem_req    = 1'b0;
    dmem_wait   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmem_req = access;
        if (access && !dmem_ready) begin
          state_d   = ST_WAIT;
          to_cnt_d  = '0;
          dmem_wait = 1'b1;
        end
      end
      ST_WAIT: begin
        timeout_hit = (to_cnt_q == TO_LIMIT);
        if (dmem_ready) begin
          // ready wins over a coincident timeout
          dmem_req = 1'b1;
          state_d  = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end else begin
          dmem_req  = 1'b1;
          dmem_wait = 1'b1;
          to_cnt_d  = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data-memory state, timeout counter and bus-error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      bus_error_q <= timeout_hit & ~dmem_ready;
    end
  end

  // A mul/div start is only accepted when the unit is idle and MEM is not held
  assign md_start_ok = ex_muldiv_start & ~muldiv_busy & ~mem_stall;

  // Mul/div busy down-counter
  always_ff @(posedge clock) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else if (md_start_ok) begin
      md_cnt_q <= MD_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_q <= md_cnt_q - MD_W'(1);
    end
  end

  // Stall-cycle statistics counter, wraps naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (if_stall) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign muldiv_busy       = (md_cnt_q != '0);
  assign mem_stall         = dmem_wait;
  assign ex_stall          = mem_stall | (muldiv_busy & (ex_muldiv_use | ex_muldiv_start));
  assign id_stall          = ex_stall | load_use | branch_haz;
  assign if_stall          = id_stall;
  assign bus_error         = bus_error_q;
  assign stall_cycle_count = stall_cnt_q;

endmodule
